data_bus_arbiter: RTL and testbench

- Shares the single 8-bit accelerator data bus (data_bus_out / data_bus_valid / bus_ready) between NUM_REQ byte sources, e.g. SPI ingress, AES core and SHA core.
- Arbitration is round-robin and burst-granular: a winner keeps the bus until its declared byte count has transferred.
- After each burst the arbiter pulses a per-source ack, which feeds the control block's ack_in.

---
 rtl/ctrl_pkg.sv | 20 ++
 rtl/rr_picker.sv | 30 +++
 rtl/data_bus_arbiter.sv | 125 ++++++++++++
 tb/tb_data_bus_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared control definitions for the accelerator bus arbiter and request scheduler.
// No logic: arbiter state encoding, source index map and default widths.
// Consumers pull these in with import ctrl_pkg::*.
package ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam int SRC_SPI  = 0;
    localparam int SRC_AES  = 1;
    localparam int SRC_SHA  = 2;
    localparam int NUM_SRC  = 3;

    // Burst-length field width; a field value of 0 means 2**DEF_LENW bytes.
    localparam int DEF_LENW = 6;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first set req bit scanning upward from last+1, wrapping.
// Latency: purely combinational.
// Backpressure: none; win_vld low when no request is pending.
module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int IDXW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDXW-1:0]    last,
    output logic [IDXW-1:0]    win_idx,
    output logic               win_vld
);

    logic [IDXW-1:0] cand_idx;

    always_comb begin
        win_idx  = '0;
        win_vld  = 1'b0;
        cand_idx = '0;
        // Offsets 1..NUM_REQ put the previous owner last in line.
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand_idx = IDXW'((int'(last) + i) % NUM_REQ);
            if (!win_vld && req[cand_idx]) begin
                win_vld = 1'b1;
                win_idx = cand_idx;
            end
        end
    end

endmodule

// File: rtl/data_bus_arbiter.sv
// Burst-granular round-robin arbiter for the shared 8-bit accelerator data bus.
// Latency: grant 1 cycle after req while idle; bytes pass through combinationally; ack 1 cycle after last beat.
// Backpressure: bus_ready is forwarded to the owner's src_ready only; a beat stalls (count held) while it is low.
module data_bus_arbiter
    import ctrl_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int LENW    = DEF_LENW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*LENW-1:0] req_len,
    input  logic [NUM_REQ*8-1:0]    src_data,
    input  logic [NUM_REQ-1:0]      src_valid,
    output logic [NUM_REQ-1:0]      src_ready,
    output logic [NUM_REQ-1:0]      grant,
    output logic [NUM_REQ-1:0]      ack,
    output logic [7:0]              data_bus_out,
    output logic                    data_bus_valid,
    input  logic                    bus_ready,
    output logic                    busy
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t         state, state_nxt;
    logic [NUM_REQ-1:0] grant_nxt, ack_nxt;
    logic [LENW-1:0]    cnt, cnt_nxt;
    logic [IDXW-1:0]    owner, owner_nxt;
    logic [IDXW-1:0]    last, last_nxt;
    logic [IDXW-1:0]    win_idx;
    logic               win_vld;
    logic               in_xfer;
    logic               beat;
    logic [7:0]         data_arr [NUM_REQ];
    logic [LENW-1:0]    len_arr  [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign data_arr[i] = src_data[i*8 +: 8];
        assign len_arr[i]  = req_len[i*LENW +: LENW];
    end

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDXW    (IDXW)
    ) u_rr_picker (
        .req     (req),
        .last    (last),
        .win_idx (win_idx),
        .win_vld (win_vld)
    );

    assign in_xfer = (state == XFER);
    assign beat    = in_xfer & src_valid[owner] & bus_ready;
    assign busy    = (state != IDLE);

    always_comb begin
        data_bus_out   = 8'h00;
        data_bus_valid = 1'b0;
        src_ready      = '0;
        if (in_xfer) begin
            data_bus_out     = data_arr[owner];
            data_bus_valid   = src_valid[owner];
            src_ready[owner] = bus_ready;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        ack_nxt   = '0;
        cnt_nxt   = cnt;
        owner_nxt = owner;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    state_nxt = XFER;
                    grant_nxt = NUM_REQ'(1) << win_idx;
                    owner_nxt = win_idx;
                    cnt_nxt   = len_arr[win_idx];
                end
            end
            XFER: begin
                // A zero length wraps to all-ones here, giving 2**LENW beats.
                if (beat) begin
                    cnt_nxt = cnt - LENW'(1);
                    if (cnt == LENW'(1)) begin
                        state_nxt = DONE;
                        grant_nxt = '0;
                        ack_nxt   = NUM_REQ'(1) << owner;
                        last_nxt  = owner;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= '0;
            ack   <= '0;
            cnt   <= '0;
            owner <= '0;
            last  <= IDXW'(NUM_REQ - 1);
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            ack   <= ack_nxt;
            cnt   <= cnt_nxt;
            owner <= owner_nxt;
            last  <= last_nxt;
        end
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Randomised bench for data_bus_arbiter: source agents push burst payloads into a scoreboard,
// a monitor tracks bus ownership from round-robin rules and checks every cycle and every beat.
module tb_data_bus_arbiter;

    localparam int N  = 3;
    localparam int LW = 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req;
    logic [N*LW-1:0]   req_len;
    logic [N*8-1:0]    src_data;
    logic [N-1:0]      src_valid;
    logic [N-1:0]      src_ready;
    logic [N-1:0]      grant;
    logic [N-1:0]      ack;
    logic [7:0]        data_bus_out;
    logic              data_bus_valid;
    logic              bus_ready;
    logic              busy;

    always #5 clk = ~clk;

    data_bus_arbiter #(.NUM_REQ(N), .LENW(LW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (req),
        .req_len        (req_len),
        .src_data       (src_data),
        .src_valid      (src_valid),
        .src_ready      (src_ready),
        .grant          (grant),
        .ack            (ack),
        .data_bus_out   (data_bus_out),
        .data_bus_valid (data_bus_valid),
        .bus_ready      (bus_ready),
        .busy           (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Source agents: per-source burst scripts, outstanding payload, scoreboard copy.
    int         len_q [N][$];
    logic [7:0] pay_q [N][$];
    logic [7:0] exp_q [N][$];
    bit         act_s [N];
    bit         dropped [N];
    int         gap [N];
    int         p_valid  = 100;
    int         p_ready  = 100;
    int         gap_max  = 0;
    int         p_drop   = 0;
    int         pat_base = -1;

    // Reference view of the bus: who owns it, bytes left, who is being acked.
    int m_owner  = -1;
    int m_left   = 0;
    int m_ack    = -1;
    int m_last   = N - 1;
    int beat_cnt = 0;

    initial begin : driver
        logic [N-1:0] hs;
        logic [7:0]   b;
        int           l;
        int           n;
        req       = '0;
        req_len   = '0;
        src_data  = '0;
        src_valid = '0;
        bus_ready = 1'b0;
        forever begin
            @(negedge clk);
            hs = src_ready & src_valid;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (!rst_n) begin
                    pay_q[i].delete();
                    len_q[i].delete();
                    act_s[i]   = 1'b0;
                    dropped[i] = 1'b0;
                    gap[i]     = 0;
                end else begin
                    if (hs[i] && pay_q[i].size() > 0) void'(pay_q[i].pop_front());
                    if (act_s[i] && pay_q[i].size() == 0) begin
                        act_s[i]   = 1'b0;
                        dropped[i] = 1'b0;
                        gap[i]     = int'($urandom_range(gap_max, 0));
                    end
                    if (!act_s[i] && gap[i] > 0) begin
                        gap[i]--;
                    end else if (!act_s[i] && len_q[i].size() > 0) begin
                        l = len_q[i].pop_front();
                        n = (l == 0) ? 64 : l;
                        for (int k = 0; k < n; k++) begin
                            b = (pat_base >= 0) ? 8'(pat_base + k) : 8'($urandom);
                            pay_q[i].push_back(b);
                            exp_q[i].push_back(b);
                        end
                        req_len[i*LW +: LW] = LW'(l);
                        act_s[i] = 1'b1;
                    end
                    // Once granted, an owner may drop req and rewrite its length; both must be ignored.
                    if (act_s[i] && !dropped[i] && grant[i] && $urandom_range(99, 0) < p_drop) begin
                        dropped[i] = 1'b1;
                        req_len[i*LW +: LW] = LW'(7);
                    end
                end
                req[i]       = act_s[i] && !dropped[i];
                src_valid[i] = act_s[i] && pay_q[i].size() > 0 && ($urandom_range(99, 0) < p_valid);
                src_data[i*8 +: 8] = src_valid[i] ? pay_q[i][0] : 8'($urandom);
            end
            bus_ready = ($urandom_range(99, 0) < p_ready);
        end
    end

    initial begin : monitor
        logic [N-1:0] e_grant, e_ack, e_rdy;
        logic [7:0]   e_dout;
        logic         e_dv;
        int           c;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_owner = -1;
                m_ack   = -1;
                m_last  = N - 1;
                for (int i = 0; i < N; i++) exp_q[i].delete();
            end
            e_grant = (m_owner >= 0) ? N'(1) << m_owner : '0;
            e_ack   = (m_ack >= 0) ? N'(1) << m_ack : '0;
            e_rdy   = (m_owner >= 0 && bus_ready) ? N'(1) << m_owner : '0;
            e_dv    = (m_owner >= 0) ? src_valid[m_owner] : 1'b0;
            e_dout  = (m_owner >= 0) ? src_data[m_owner*8 +: 8] : 8'h00;
            check("grant", grant, e_grant);
            check("ack", ack, e_ack);
            check("busy", busy, (m_owner >= 0 || m_ack >= 0));
            check("src_ready", src_ready, e_rdy);
            check("data_bus_valid", data_bus_valid, e_dv);
            check("data_bus_out", data_bus_out, e_dout);
            check("ack_and_grant", ack & grant, 0);
            if (!rst_n) continue;
            if (m_ack >= 0) begin
                m_ack = -1;
            end else if (m_owner < 0) begin
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (req[c]) begin
                        m_owner = c;
                        m_left  = int'(req_len[c*LW +: LW]);
                        if (m_left == 0) m_left = 64;
                        break;
                    end
                end
            end else if (src_valid[m_owner] && bus_ready) begin
                beat_cnt++;
                if (exp_q[m_owner].size() == 0) check("beat_underflow", 1, 0);
                else check("beat_data", data_bus_out, exp_q[m_owner].pop_front());
                m_left--;
                if (m_left == 0) begin
                    m_ack   = m_owner;
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end
        end
    end

    function automatic bit all_idle();
        bit r;
        r = (m_owner < 0) && (m_ack < 0);
        for (int i = 0; i < N; i++)
            if (act_s[i] || len_q[i].size() > 0) r = 1'b0;
        return r;
    endfunction

    task automatic wait_idle(input string nm, input int budget);
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            #1;
            if (all_idle()) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bus still busy after %0d cycles, expected idle", nm, budget);
    endtask

    task automatic wait_grant(input string nm, input int budget, output bit seen);
        seen = 1'b0;
        for (int t = 0; t < budget && !seen; t++) begin
            @(negedge clk);
            #1;
            if (grant != '0) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no grant within %0d cycles, expected one", nm, budget);
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit seen;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // Single 4-byte burst from source 0 carrying A0..A3.
        pat_base = 8'hA0;
        beat_cnt = 0;
        len_q[0].push_back(4);
        wait_idle("burst_len4", 200);
        check("burst_len4_beats", beat_cnt, 4);
        pat_base = -1;

        // All sources requesting continuously with length 1.
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < N; i++) len_q[i].push_back(1);
        wait_idle("rr_len1", 200);

        // Owner 1 with length 3 under a toggling sink.
        p_ready = 50;
        for (int r = 0; r < 4; r++) len_q[1].push_back(3);
        wait_idle("stall_len3", 500);

        // Owner drops req and rewrites req_len right after grant.
        p_ready = 100;
        p_drop  = 100;
        len_q[0].push_back(2);
        len_q[0].push_back(5);
        wait_idle("drop_req", 200);
        p_drop = 0;

        // Length field 0 means 64 bytes.
        beat_cnt = 0;
        len_q[2].push_back(0);
        wait_idle("len0", 500);
        check("len0_beats", beat_cnt, 64);

        // Randomised mixed traffic.
        for (int round = 0; round < 4; round++) begin
            p_valid = int'($urandom_range(100, 40));
            p_ready = int'($urandom_range(100, 30));
            gap_max = int'($urandom_range(3, 0));
            p_drop  = 20;
            for (int i = 0; i < N; i++)
                for (int k = 0; k < 8; k++)
                    len_q[i].push_back(($urandom_range(9, 0) == 0) ? 0 : int'($urandom_range(10, 1)));
            wait_idle("random_round", 20000);
        end

        // Reset asserted during the second beat of a 5-byte burst.
        p_valid = 100;
        p_ready = 100;
        gap_max = 0;
        p_drop  = 0;
        len_q[0].push_back(5);
        wait_grant("rst_burst_grant", 50, seen);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_grant", grant, 0);
        check("rst_data_bus_valid", data_bus_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ack", ack, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        len_q[1].push_back(2);
        len_q[0].push_back(2);
        wait_grant("post_rst_grant", 50, seen);
        if (seen) check("post_rst_first_winner", grant, 3'b001);
        wait_idle("post_rst", 200);

        for (int i = 0; i < N; i++) check("exp_q_leftover", exp_q[i].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
